pc_fetch_unit: RTL and testbench

//   Program-counter / fetch stage directly upstream of the IF/ID pipeline register.

---
 rtl/aurora_fetch_pkg.sv | 20 ++
 rtl/pc_fetch_unit_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aurora_fetch_pkg.sv
// rtl/aurora_fetch_pkg.sv - shared fetch-stage state encoding and PC width
package aurora_fetch_pkg;

  localparam int DEFAULT_INSTMEM_LOG2_DEEP = 8;
  localparam int DEFAULT_CNT_W             = 16;

  // 2'b11 is unused; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INCR   = 2'b01,
    PC_BRANCH = 2'b10
  } pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - control inputs and IF/ID-facing outputs of the fetch stage
interface pc_fetch_unit_if
  import aurora_fetch_pkg::*;
#(
  parameter int INSTMEM_LOG2_DEEP = DEFAULT_INSTMEM_LOG2_DEEP,
  parameter int CNT_W             = DEFAULT_CNT_W
);

  logic                         start;
  logic                         hazard;
  logic                         branch_taken;
  logic [INSTMEM_LOG2_DEEP-1:0] branch_target;
  logic                         halt_req;

  logic [INSTMEM_LOG2_DEEP-1:0] PC_out;
  logic                         wb_ff_out;
  logic                         flush_out;
  logic                         running;
  logic                         halted;
  logic [CNT_W-1:0]             fetch_cnt;

  // The fetch unit is the master: it owns the PC and the IF/ID feed.
  modport master (
    input  start, hazard, branch_taken, branch_target, halt_req,
    output PC_out, wb_ff_out, flush_out, running, halted, fetch_cnt
  );

  modport slave (
    output start, hazard, branch_taken, branch_target, halt_req,
    input  PC_out, wb_ff_out, flush_out, running, halted, fetch_cnt
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter / fetch stage feeding the IF/ID register
module pc_fetch_unit
  import aurora_fetch_pkg::*;
#(
  parameter int INSTMEM_LOG2_DEEP = DEFAULT_INSTMEM_LOG2_DEEP,
  parameter int RESET_PC          = 0,
  parameter int CNT_W             = DEFAULT_CNT_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  pc_fetch_unit_if.master    bus
);

  localparam logic [INSTMEM_LOG2_DEEP-1:0] RESET_PC_V = RESET_PC[INSTMEM_LOG2_DEEP-1:0];
  localparam logic [INSTMEM_LOG2_DEEP-1:0] PC_ONE     = {{(INSTMEM_LOG2_DEEP-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]             CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]             CNT_MAX    = {CNT_W{1'b1}};

  fetch_state_t                 state_q, state_d;
  pc_sel_t                      pc_sel;
  logic [INSTMEM_LOG2_DEEP-1:0] pc_q, pc_d;
  logic                         wb_q, wb_d;
  logic                         flush_q, flush_d;
  logic                         running_q, halted_q;
  logic [CNT_W-1:0]             cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN priority: halt_req > branch_taken > hazard > advance.
  always_comb begin
    state_d = state_q;
    pc_sel  = PC_HOLD;
    wb_d    = wb_q;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wb_d = 1'b0;
        if (bus.start) begin
          state_d = ST_RUN;
          wb_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
          wb_d    = 1'b0;
        end else if (bus.branch_taken) begin
          pc_sel  = PC_BRANCH;
          wb_d    = 1'b1;
          flush_d = 1'b1;
        end else if (!bus.hazard) begin
          pc_sel = PC_INCR;
          wb_d   = 1'b1;
        end
      end
      ST_HALT: begin
        wb_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        wb_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INCR:   pc_d = pc_q + PC_ONE;
      PC_BRANCH: pc_d = bus.branch_target;
      default:   pc_d = pc_q;
    endcase
  end

  // Status flags follow the next state so they line up with PC_out/wb_ff_out.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q      <= RESET_PC_V;
      wb_q      <= 1'b0;
      flush_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      wb_q      <= wb_d;
      flush_q   <= flush_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (wb_d && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.PC_out    = pc_q;
  assign bus.wb_ff_out = wb_q;
  assign bus.flush_out = flush_q;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed bench for pc_fetch_unit with a cycle-level reference model
module tb_pc_fetch_unit;

  localparam int N     = 8;
  localparam int CW    = 4;
  localparam int RPC   = 0;
  localparam int PCMOD = 1 << N;
  localparam int CMAX  = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST_N;

  pc_fetch_unit_if #(.INSTMEM_LOG2_DEEP(N), .CNT_W(CW)) ifc ();

  pc_fetch_unit #(.INSTMEM_LOG2_DEEP(N), .RESET_PC(RPC), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifc.master)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle, 1=running, 2=halted.
  int m_mode, m_pc, m_cnt;
  bit m_wb, m_flush, m_valid = 1'b0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_mode = 0; m_pc = RPC; m_wb = 0; m_flush = 0; m_cnt = 0; m_valid = 1;
    end else if (m_valid) begin
      m_flush = 0;
      if (m_mode == 0) begin
        m_wb = 0;
        if (ifc.start) begin m_mode = 1; m_wb = 1; end
      end else if (m_mode == 1) begin
        if (ifc.halt_req) begin
          m_mode = 2; m_wb = 0;
        end else if (ifc.branch_taken) begin
          m_pc = int'(ifc.branch_target); m_wb = 1; m_flush = 1;
        end else if (!ifc.hazard) begin
          m_pc = (m_pc + 1) % PCMOD; m_wb = 1;
        end
      end else begin
        m_wb = 0;
      end
      if (m_wb && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_pc",      32'(ifc.PC_out),    32'(m_pc));
      chk("model_wb",      32'(ifc.wb_ff_out), 32'(m_wb));
      chk("model_flush",   32'(ifc.flush_out), 32'(m_flush));
      chk("model_running", 32'(ifc.running),   32'(m_mode == 1));
      chk("model_halted",  32'(ifc.halted),    32'(m_mode == 2));
      chk("model_cnt",     32'(ifc.fetch_cnt), 32'(m_cnt));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic clear_inputs();
    ifc.start = 0; ifc.hazard = 0; ifc.branch_taken = 0;
    ifc.branch_target = '0; ifc.halt_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    clear_inputs();
    tick(2);
    chk("reset_pc", 32'(ifc.PC_out), 32'h0);
    chk("reset_cnt", 32'(ifc.fetch_cnt), 32'h0);

    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_pc", 32'(ifc.PC_out), 32'h0);
      chk("idle_wb", 32'(ifc.wb_ff_out), 32'h0);
      chk("idle_running", 32'(ifc.running), 32'h0);
    end

    ifc.start = 1; tick(); ifc.start = 0;
    chk("start_pc", 32'(ifc.PC_out), 32'h0);
    chk("start_wb", 32'(ifc.wb_ff_out), 32'h1);
    chk("start_running", 32'(ifc.running), 32'h1);
    chk("start_cnt", 32'(ifc.fetch_cnt), 32'd1);
    tick(3);
    chk("seq_pc3", 32'(ifc.PC_out), 32'h3);
    chk("seq_cnt4", 32'(ifc.fetch_cnt), 32'd4);
    tick(2);
    chk("pre_hazard_pc", 32'(ifc.PC_out), 32'h5);

    ifc.hazard = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hazard_hold_pc", 32'(ifc.PC_out), 32'h5);
    end
    chk("hazard_cnt", 32'(ifc.fetch_cnt), 32'd9);
    ifc.hazard = 0; tick();
    chk("post_hazard_pc", 32'(ifc.PC_out), 32'h6);
    chk("post_hazard_cnt", 32'(ifc.fetch_cnt), 32'd10);
    tick(3);
    chk("pre_branch_pc", 32'(ifc.PC_out), 32'h9);

    ifc.branch_taken = 1; ifc.branch_target = 8'h40; ifc.hazard = 1; tick();
    clear_inputs();
    chk("branch_pc", 32'(ifc.PC_out), 32'h40);
    chk("branch_flush", 32'(ifc.flush_out), 32'h1);
    tick();
    chk("branch_next_pc", 32'(ifc.PC_out), 32'h41);
    chk("branch_flush_clr", 32'(ifc.flush_out), 32'h0);
    chk("cnt_sat_reach", 32'(ifc.fetch_cnt), 32'd15);

    ifc.branch_taken = 1; ifc.branch_target = 8'hFE; tick(); clear_inputs();
    chk("wrap_fe", 32'(ifc.PC_out), 32'hFE);
    tick();
    chk("wrap_ff", 32'(ifc.PC_out), 32'hFF);
    tick();
    chk("wrap_00", 32'(ifc.PC_out), 32'h00);
    chk("wrap_wb", 32'(ifc.wb_ff_out), 32'h1);
    chk("cnt_saturated", 32'(ifc.fetch_cnt), 32'd15);

    ifc.branch_taken = 1; ifc.branch_target = 8'h12; tick(); clear_inputs();
    chk("pre_halt_pc", 32'(ifc.PC_out), 32'h12);
    ifc.halt_req = 1; ifc.branch_taken = 1; ifc.branch_target = 8'h55; tick(); clear_inputs();
    chk("halt_pc", 32'(ifc.PC_out), 32'h12);
    chk("halt_wb", 32'(ifc.wb_ff_out), 32'h0);
    chk("halt_halted", 32'(ifc.halted), 32'h1);
    chk("halt_flush", 32'(ifc.flush_out), 32'h0);
    ifc.start = 1; tick(); clear_inputs();
    ifc.branch_taken = 1; ifc.branch_target = 8'h77; tick(); clear_inputs();
    ifc.hazard = 1; tick(); clear_inputs();
    tick();
    chk("halt_absorb_pc", 32'(ifc.PC_out), 32'h12);
    chk("halt_absorb_halted", 32'(ifc.halted), 32'h1);

    RST_N = 0; tick(); RST_N = 1;
    chk("rst_pc", 32'(ifc.PC_out), 32'(RPC));
    chk("rst_halted", 32'(ifc.halted), 32'h0);
    chk("rst_wb", 32'(ifc.wb_ff_out), 32'h0);
    chk("rst_cnt", 32'(ifc.fetch_cnt), 32'h0);
    tick(2);
    ifc.start = 1; tick(); ifc.start = 0;
    tick(20);
    chk("rerun_pc", 32'(ifc.PC_out), 32'h14);
    chk("rerun_cnt_sat", 32'(ifc.fetch_cnt), 32'd15);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
